// File: rtl/div_seq_ctrl.sv
// Multicycle sequencer around a combinational restoring divider: takes magnitudes, waits for the divider to settle, applies signs.
// Optional macro DIV_UNSIGNED_OP_EN adds an is_unsigned input for raw unsigned division.
module div_seq_ctrl #(
    parameter int WIDTH         = 32,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
`ifdef DIV_UNSIGNED_OP_EN
    input  logic             is_unsigned,
`endif
    output logic [WIDTH-1:0] div_dividend,
    output logic [WIDTH-1:0] div_divisor,
    input  logic [WIDTH-1:0] div_quotient,
    output logic [WIDTH-1:0] zlo,
    output logic [WIDTH-1:0] zhi,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT,
        S_FIX,
        S_DONE
    } state_t;

    localparam int CNT_W = 4;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic             sa_q, sb_q;
    logic             uns_q;
    logic [WIDTH-1:0] dvd_q, dvs_q;
    logic [WIDTH-1:0] zlo_q, zhi_q;
    logic             busy_q, done_q, dbz_q;

    logic [WIDTH-1:0] prod, rem_u;
    logic [WIDTH-1:0] fix_q_d, fix_r_d;

    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
        return ~v + WIDTH'(1);
    endfunction

`ifndef DIV_UNSIGNED_OP_EN
    assign uns_q = 1'b0;
`endif

    // Remainder is recovered from the quotient: only the low WIDTH bits matter.
    always_comb begin
        prod    = div_quotient * dvs_q;
        rem_u   = dvd_q - prod;
        fix_q_d = div_quotient;
        fix_r_d = rem_u;
        if (b_q == '0) begin
            fix_q_d = '1;
            fix_r_d = a_q;
        end else if (!uns_q) begin
            fix_q_d = (sa_q ^ sb_q) ? negate(div_quotient) : div_quotient;
            fix_r_d = sa_q ? negate(rem_u) : rem_u;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
`ifdef DIV_UNSIGNED_OP_EN
            uns_q   <= 1'b0;
`endif
            dvd_q   <= '0;
            dvs_q   <= '0;
            zlo_q   <= '0;
            zhi_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        a_q     <= op_a;
                        b_q     <= op_b;
                        sa_q    <= op_a[WIDTH-1];
                        sb_q    <= op_b[WIDTH-1];
`ifdef DIV_UNSIGNED_OP_EN
                        uns_q   <= is_unsigned;
`endif
                        dbz_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    dvd_q   <= (sa_q && !uns_q) ? negate(a_q) : a_q;
                    dvs_q   <= (sb_q && !uns_q) ? negate(b_q) : b_q;
                    // One edge beyond the settle count so done lands SETTLE_CYCLES+3 edges after accept.
                    cnt_q   <= CNT_W'(SETTLE_CYCLES);
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (cnt_q == '0) begin
                        state_q <= S_FIX;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                S_FIX: begin
                    zlo_q   <= fix_q_d;
                    zhi_q   <= fix_r_d;
                    dbz_q   <= (b_q == '0);
                    done_q  <= 1'b1;
                    state_q <= S_DONE;
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign div_dividend = dvd_q;
    assign div_divisor  = dvs_q;
    assign zlo          = zlo_q;
    assign zhi          = zhi_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign div_by_zero  = dbz_q;

endmodule
